// File: rtl/hwpe_ctrl_ucode_loader.sv
// Microcode bundle loader: streams 32-bit words into a shadow buffer and commits
// it to the active bundle while the sequencer is idle. Optional checksum word: HWPE_UCODE_LOADER_CHECK_EN.
module hwpe_ctrl_ucode_loader #(
  parameter  int LENGTH    = 16,
  parameter  int NB_LOOPS  = 6,
  parameter  int CNT_WIDTH = 12,
  localparam int UCODE_W   = LENGTH*11 + NB_LOOPS*8 + NB_LOOPS*CNT_WIDTH,
  localparam int NB_WORDS  = (UCODE_W + 31) / 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [31:0]        wr_data_i,
  input  logic               wr_last_i,
  input  logic               seq_busy_i,
  output logic [UCODE_W-1:0] ucode_o,
  output logic               ucode_valid_o,
  output logic               committed_o,
  output logic               error_o
);

  localparam int WCNT_W = $clog2(NB_WORDS + 1);
`ifdef HWPE_UCODE_LOADER_CHECK_EN
  localparam int FINAL_IDX_INT = NB_WORDS;
`else
  localparam int FINAL_IDX_INT = NB_WORDS - 1;
`endif
  localparam logic [WCNT_W-1:0] FINAL_IDX = WCNT_W'(FINAL_IDX_INT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [WCNT_W-1:0]    wcnt_reg;
  logic [UCODE_W-1:0]   shadow_reg;
  logic [UCODE_W-1:0]   shadow_next;
  logic                 wr_ready;
  logic                 commit;
  logic                 accept;
  logic                 final_word;
  logic                 sum_ok;
  logic                 load_ok;
  logic                 load_bad;

  assign wr_ready_o = wr_ready;
  assign accept     = wr_valid_i & wr_ready;
  assign final_word = (wcnt_reg == FINAL_IDX);
  assign load_ok    = accept & final_word & wr_last_i & sum_ok;
  // The final word must carry last (and a good checksum); any earlier word must not.
  assign load_bad   = accept & (final_word ? ~(wr_last_i & sum_ok) : wr_last_i);

`ifdef HWPE_UCODE_LOADER_CHECK_EN
  logic [31:0] csum_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || load_bad || load_ok) begin
      csum_reg <= '0;
    end else if (accept) begin
      csum_reg <= csum_reg ^ wr_data_i;
    end
  end

  assign sum_ok = (wr_data_i == csum_reg);
`else
  assign sum_ok = 1'b1;
`endif

  // Per-word write decode; the last word is truncated to the bundle width.
  generate
    for (genvar gi = 0; gi < NB_WORDS; gi++) begin : g_word
      localparam int LO = gi * 32;
      localparam int W  = ((UCODE_W - LO) > 32) ? 32 : (UCODE_W - LO);
      assign shadow_next[LO +: W] = (accept && (wcnt_reg == WCNT_W'(gi)))
                                    ? wr_data_i[W-1:0] : shadow_reg[LO +: W];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, LOAD: begin
          if (load_bad) begin
            state_next = IDLE;
          end else if (load_ok) begin
            state_next = FULL;
          end else if (accept) begin
            state_next = LOAD;
          end
        end
        FULL: begin
          if (!seq_busy_i) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ready = 1'b1;
    commit   = 1'b0;
    case (state_reg)
      FULL: begin
        wr_ready = 1'b0;
        commit   = ~seq_busy_i & ~clear_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_reg      <= '0;
      shadow_reg    <= '0;
      ucode_o       <= '0;
      ucode_valid_o <= 1'b0;
      committed_o   <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      committed_o <= commit;
      if (commit) begin
        ucode_o       <= shadow_reg;
        ucode_valid_o <= 1'b1;
      end
      if (clear_i) begin
        wcnt_reg   <= '0;
        shadow_reg <= '0;
        error_o    <= 1'b0;
      end else if (load_bad) begin
        wcnt_reg   <= '0;
        shadow_reg <= '0;
        error_o    <= 1'b1;
      end else if (accept) begin
        shadow_reg <= shadow_next;
        if (!final_word) begin
          wcnt_reg <= wcnt_reg + WCNT_W'(1);
        end
        if (wcnt_reg == '0) begin
          error_o <= 1'b0;
        end
      end else if (commit) begin
        wcnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_ucode_loader.sv
// Directed self-checking bench for hwpe_ctrl_ucode_loader at default parameters.
module tb_hwpe_ctrl_ucode_loader;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clear_i;
  logic         wr_valid_i;
  logic         wr_ready_o;
  logic [31:0]  wr_data_i;
  logic         wr_last_i;
  logic         seq_busy_i;
  logic [295:0] ucode_o;
  logic         ucode_valid_o;
  logic         committed_o;
  logic         error_o;

  int n_cmp = 0;
  int n_err = 0;

  hwpe_ctrl_ucode_loader dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_data_i     (wr_data_i),
    .wr_last_i     (wr_last_i),
    .seq_busy_i    (seq_busy_i),
    .ucode_o       (ucode_o),
    .ucode_valid_o (ucode_valid_o),
    .committed_o   (committed_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_last_i  = last;
    step();
    $display("word %08h last=%0b ready_after=%0b err=%0b", d, last, wr_ready_o, error_o);
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  initial begin
    rst_i      = 1'b1;
    clear_i    = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    wr_last_i  = 1'b0;
    seq_busy_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;

    chk("rst_ready", 32'(wr_ready_o), 32'd1);
    chk("rst_ucode_lo", ucode_o[31:0], 32'd0);
    chk("rst_ucode_hi", 32'(ucode_o[295:288]), 32'd0);
    chk("rst_valid", 32'(ucode_valid_o), 32'd0);
    chk("rst_committed", 32'(committed_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);

`ifndef HWPE_UCODE_LOADER_CHECK_EN
    // Basic load
    for (int k = 0; k < 10; k++) send(32'h1000_0000 + 32'(k), k == 9);
    chk("basic_full_ready", 32'(wr_ready_o), 32'd0);
    chk("basic_pre_commit", 32'(committed_o), 32'd0);
    step();
    chk("basic_committed", 32'(committed_o), 32'd1);
    chk("basic_w0", ucode_o[31:0], 32'h1000_0000);
    chk("basic_w1", ucode_o[63:32], 32'h1000_0001);
    chk("basic_top", 32'(ucode_o[295:288]), 32'h09);
    chk("basic_valid", 32'(ucode_valid_o), 32'd1);
    chk("basic_ready", 32'(wr_ready_o), 32'd1);
    step();
    chk("basic_pulse_end", 32'(committed_o), 32'd0);

    // Busy hold
    seq_busy_i = 1'b1;
    for (int k = 0; k < 10; k++) send(32'h2000_0000 + 32'(k), k == 9);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("busy_ready", 32'(wr_ready_o), 32'd0);
      chk("busy_w0", ucode_o[31:0], 32'h1000_0000);
      chk("busy_no_commit", 32'(committed_o), 32'd0);
    end
    seq_busy_i = 1'b0;
    step();
    chk("busy_committed", 32'(committed_o), 32'd1);
    chk("busy_w0_new", ucode_o[31:0], 32'h2000_0000);
    step();

    // Early last on word 4
    for (int k = 0; k < 5; k++) send(32'h3000_0000 + 32'(k), k == 4);
    chk("early_error", 32'(error_o), 32'd1);
    chk("early_ready", 32'(wr_ready_o), 32'd1);
    step();
    chk("early_no_commit", 32'(committed_o), 32'd0);
    chk("early_retained", ucode_o[31:0], 32'h2000_0000);

    // Missing last; its first word also clears the sticky error
    send(32'h4000_0000, 1'b0);
    chk("err_cleared", 32'(error_o), 32'd0);
    for (int k = 1; k < 10; k++) send(32'h4000_0000 + 32'(k), 1'b0);
    chk("missing_error", 32'(error_o), 32'd1);
    chk("missing_ready", 32'(wr_ready_o), 32'd1);
    step();
    chk("missing_no_commit", 32'(committed_o), 32'd0);
    chk("missing_retained", ucode_o[31:0], 32'h2000_0000);

    // Clear after word 6, then a full load
    for (int k = 0; k < 7; k++) send(32'h5000_0000 + 32'(k), 1'b0);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clear_ready", 32'(wr_ready_o), 32'd1);
    chk("clear_error", 32'(error_o), 32'd0);
    chk("clear_valid", 32'(ucode_valid_o), 32'd1);
    chk("clear_retained", ucode_o[31:0], 32'h2000_0000);
    for (int k = 0; k < 10; k++) send(32'h6000_0000 + 32'(k), k == 9);
    step();
    chk("after_clear_commit", 32'(committed_o), 32'd1);
    chk("after_clear_w0", ucode_o[31:0], 32'h6000_0000);
    chk("after_clear_w1", ucode_o[63:32], 32'h6000_0001);
    chk("after_clear_top", 32'(ucode_o[295:288]), 32'h09);
    step();

    // Clear coincident with a word: the word must be dropped
    wr_valid_i = 1'b1;
    wr_data_i  = 32'h7000_0000;
    clear_i    = 1'b1;
    step();
    wr_valid_i = 1'b0;
    clear_i    = 1'b0;
    for (int k = 0; k < 10; k++) send(32'h8000_0000 + 32'(k), k == 9);
    chk("drop_no_error", 32'(error_o), 32'd0);
    step();
    chk("drop_commit", 32'(committed_o), 32'd1);
    chk("drop_w0", ucode_o[31:0], 32'h8000_0000);
    chk("drop_w9", 32'(ucode_o[295:288]), 32'h09);
`else
    // Checksum good: XOR of ten identical words is zero
    for (int k = 0; k < 10; k++) send(32'hA5A5_A5A5, 1'b0);
    chk("cs_not_full", 32'(wr_ready_o), 32'd1);
    send(32'h0000_0000, 1'b1);
    chk("cs_full", 32'(wr_ready_o), 32'd0);
    step();
    chk("cs_commit", 32'(committed_o), 32'd1);
    chk("cs_w0", ucode_o[31:0], 32'hA5A5_A5A5);
    chk("cs_top", 32'(ucode_o[295:288]), 32'hA5);
    chk("cs_error", 32'(error_o), 32'd0);
    step();
    // Checksum bad
    for (int k = 0; k < 10; k++) send(32'hA5A5_A5A5, 1'b0);
    send(32'h0000_0001, 1'b1);
    chk("cs_bad_error", 32'(error_o), 32'd1);
    chk("cs_bad_ready", 32'(wr_ready_o), 32'd1);
    step();
    chk("cs_bad_no_commit", 32'(committed_o), 32'd0);
    // Last on a data word is rejected
    for (int k = 0; k < 10; k++) send(32'hA5A5_A5A5, k == 9);
    chk("cs_early_last", 32'(error_o), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
